sha256_k_sequencer: RTL and testbench
=====================================

Name: sha256_k_sequencer

Overview:
- Streams the 64 SHA-256 round constants, one 32-bit word per round, to the compression core over a valid/ready handshake.
- Sits between the 16 x 128-bit dual-port K-constant RAM (this block owns one port as the sole reader) and the round logic.
- Ping-pong line buffers prefetch the next 128-bit line while the current line is consumed, so a core that is always ready sees 64 back-to-back words with no bubbles.

Parameters:
- NUM_LINES, 16, RAM depth in 128-bit lines; fixed for SHA-256.
- ADDR_W, 4, RAM address width.
- LINE_W, 128, RAM data width.
- WORD_W, 32, constant width; 4 words per line.

Ports:
- clk  in  1  single clock; also clocks the RAM port this block drives.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to begin a 64-constant stream; ignored while busy.
- abort  in  1  synchronous cancel of a stream in progress.
- busy  out  1  high from the first fetch cycle through the cycle of the final handshake.
- done  out  1  one-cycle pulse after word 63 is accepted.
- k_valid  out  1  k_data/k_round hold a valid constant.
- k_ready  in  1  core accepts the word when k_valid && k_ready.
- k_data  out  32  round constant K[k_round].
- k_round  out  6  index 0..63 of k_data.
- ram_address  out  4  RAM line address.
- ram_clken  out  1  RAM port clock enable; high only in issue cycles.
- ram_readdata  in  128  RAM output; valid the cycle after issue (address registered, output unregistered).

Behaviour:
- Reset values: busy=0, done=0, k_valid=0, k_data=0, k_round=0, ram_address=0, ram_clken=0. All buffers invalid, fetch pointer and round counter 0, state IDLE.
- Word mapping: K[i] = line i>>2, bits [32*(i&3)+31 : 32*(i&3)]. Lane 0 is bits [31:0].
- States:
  - IDLE: start && !abort, sampled at edge T, enters FETCH. Fetch pointer and round counter clear to 0.
  - FETCH/STREAM: active stream.
  - IDLE is re-entered after the final handshake or on abort.
- Issue rule: in cycle C, drive ram_clken=1 and ram_address=fetch_ptr when all of these hold:
  - fetch_ptr < 16;
  - no read is outstanding;
  - (buffers valid + reads pending) < 2.
  On issue, fetch_ptr increments. At most one read is outstanding. ram_readdata is captured in cycle C+1 into the free buffer, which becomes valid at the end of C+1.
- Timing: start sampled at edge T.
  - Line 0 issued in cycle T+1.
  - Captured in T+2.
  - First k_valid in T+3 with k_round=0, k_data=K[0].
- Output rules:
  - k_valid/k_data/k_round stay stable while k_valid && !k_ready.
  - On a handshake, k_round increments.
  - After lane 3 is accepted, the active buffer is freed and the other buffer becomes active.
  - With k_ready held high, one word is delivered per cycle with no gaps. A line drains in 4 cycles and a refill takes 2.
- Completion: the handshake with k_round=63 drops busy and k_valid the next cycle. done=1 for exactly that cycle, then the block is in IDLE.
  - With constant ready: last handshake in T+66, done in T+67.
- Back-pressure: k_ready low for any length stalls delivery. No read is issued while both buffers are full. No data is lost or duplicated.
- abort (busy or not):
  - Next cycle: IDLE, k_valid=0, busy=0, ram_clken=0, no done.
  - An in-flight read result is discarded and buffers are invalidated.
  - abort and start in the same cycle: abort wins and start is ignored.
- start while busy: ignored, with no effect on the stream.
- Reset mid-stream: identical to abort, and all outputs take their reset values the next cycle.
- k_round wraps 63 -> 0 only through a new start; it never exceeds 63.

Test Plan:
- RAM model preloaded with standard SHA-256 K. start at T, k_ready=1 -> k_valid first at T+3 with K[0]=0x428a2f98. 64 consecutive words, K[63]=0xc67178f2 in T+66. done pulse only in T+67, busy low at T+67.
- Full stream with k_ready toggling pseudo-randomly (about 40% low) -> k_data stable during every stall. Sequence exactly K[0..63] in order. ram_clken never high with 2 buffers full. At most one outstanding read.
- k_ready=0 for 20 cycles after the first valid -> exactly 2 lines issued (addresses 0,1), then ram_clken stays low. On release, K[0],K[1],... resume with no duplicates.
- abort at k_round=37 mid-stall -> next cycle k_valid=0, busy=0, no done. A new start replays from K[0]=0x428a2f98.
- start held high during a stream, and start+abort together in IDLE -> stream unaffected, no second stream. Simultaneous case stays IDLE.
- reset asserted in the cycle a read is outstanding -> all outputs 0 next cycle. A subsequent start gives first word K[0] at start+3.

Source files
------------

// File: rtl/sha256_k_sequencer.sv
// sha256_k_sequencer: streams K[0..63] from a 16x128 RAM port to the round core over valid/ready, ping-pong prefetching lines
module sha256_k_sequencer #(
  parameter int NUM_LINES = 16,
  parameter int ADDR_W = 4,
  parameter int LINE_W = 128,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              k_valid,
  input  logic              k_ready,
  output logic [WORD_W-1:0] k_data,
  output logic [5:0]        k_round,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_clken,
  input  logic [LINE_W-1:0] ram_readdata
);
  localparam int LANES = LINE_W / WORD_W;
  typedef enum logic {IDLE, STREAM} state_t;
  typedef logic [LANES-1:0][WORD_W-1:0] line_t;
  state_t state_q, state_d;
  logic [ADDR_W:0] fptr_q, fptr_d;
  logic [5:0] round_q, round_d;
  logic [1:0] bval_q, bval_d, nval;
  line_t buf_q [2];
  line_t buf_d [2];
  logic pend_q, pend_d, act_q, act_d, wr_q, wr_d, done_q, done_d;
  logic active, issue, hs;
  always_comb begin
    active = state_q == STREAM;
    nval = {1'b0, bval_q[0]} + {1'b0, bval_q[1]} + {1'b0, pend_q};
    issue = active && fptr_q < (ADDR_W+1)'(NUM_LINES) && !pend_q && nval < 2'd2;
    k_valid = active && bval_q[act_q];
    hs = k_valid && k_ready;
    state_d = state_q;
    fptr_d = fptr_q;
    round_d = round_q;
    bval_d = bval_q;
    buf_d = buf_q;
    pend_d = pend_q;
    act_d = act_q;
    wr_d = wr_q;
    done_d = 1'b0;
    if (abort) begin
      state_d = IDLE;
      bval_d = '0;
      pend_d = 1'b0;
    end else if (!active) begin
      if (start) begin
        state_d = STREAM;
        fptr_d = '0;
        round_d = '0;
        bval_d = '0;
        pend_d = 1'b0;
        act_d = 1'b0;
        wr_d = 1'b0;
      end
    end else begin
      fptr_d = issue ? fptr_q + {{ADDR_W{1'b0}}, 1'b1} : fptr_q;
      pend_d = issue;
      if (pend_q) begin
        buf_d[wr_q] = ram_readdata;
        bval_d[wr_q] = 1'b1;
        wr_d = !wr_q;
      end
      if (hs) begin
        if (round_q == 6'd63) begin
          state_d = IDLE;
          done_d = 1'b1;
          bval_d = '0;
        end else begin
          round_d = round_q + 6'd1;
          if (round_q[1:0] == 2'd3) begin
            bval_d[act_q] = 1'b0;
            act_d = !act_q;
          end
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
    if (reset) begin
      state_q <= IDLE;
      fptr_q <= '0;
      round_q <= '0;
      bval_q <= '0;
      pend_q <= 1'b0;
      act_q <= 1'b0;
      wr_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fptr_q <= fptr_d;
      round_q <= round_d;
      bval_q <= bval_d;
      pend_q <= pend_d;
      act_q <= act_d;
      wr_q <= wr_d;
      done_q <= done_d;
    end
  end
  assign busy = active;
  assign done = done_q;
  assign k_round = round_q;
  assign k_data = k_valid ? buf_q[act_q][round_q[1:0]] : '0;
  assign ram_clken = issue;
  assign ram_address = issue ? fptr_q[ADDR_W-1:0] : '0;
endmodule

// File: tb/tb_sha256_k_sequencer.sv
// tb_sha256_k_sequencer: randomized self-checking bench with a RAM model and an accepted-word scoreboard
module tb_sha256_k_sequencer;
  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  logic clk = 0, reset = 1, start = 0, abort = 0, k_ready = 0;
  logic busy, done, k_valid, ram_clken;
  logic [31:0] k_data;
  logic [5:0] k_round;
  logic [3:0] ram_address, ram_addr_r = '0;
  logic [127:0] ram_readdata;
  int n_cmp = 0, n_err = 0, cyc = 0, exp_idx = 0, issued = 0, done_cnt = 0;
  int first_v, done_at, n;
  bit rnd_ready = 0, prev_stall = 0, prev_kill = 0, prev_clken = 0;
  always #5 clk = !clk;
  sha256_k_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(busy), .done(done),
    .k_valid(k_valid), .k_ready(k_ready), .k_data(k_data), .k_round(k_round),
    .ram_address(ram_address), .ram_clken(ram_clken), .ram_readdata(ram_readdata));
  always @(posedge clk) if (ram_clken) ram_addr_r <= ram_address;
  assign ram_readdata = {K_TAB[{ram_addr_r, 2'd3}], K_TAB[{ram_addr_r, 2'd2}], K_TAB[{ram_addr_r, 2'd1}], K_TAB[{ram_addr_r, 2'd0}]};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask
  always @(negedge clk) begin
    if (k_valid) begin
      check("in_range", 32'(exp_idx < 64), 1);
      check("k_round", 32'(k_round), 32'(exp_idx));
      check("k_data", k_data, K_TAB[exp_idx % 64]);
    end
    if (prev_stall && !prev_kill) check("stall_hold", 32'(k_valid), 1);
    if (ram_clken) begin
      check("one_outstanding", 32'(prev_clken), 0);
      check("buf_room", 32'((issued - exp_idx / 4) < 2), 1);
      check("ram_addr", 32'(ram_address), 32'(issued));
      issued++;
    end
    if (done) done_cnt++;
    if (k_valid && k_ready) exp_idx++;
    prev_stall = k_valid && !k_ready;
    prev_kill = abort || reset;
    prev_clken = ram_clken;
  end
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rnd_ready) k_ready = ($urandom_range(0, 99) >= 40);
  endtask
  task automatic model_clr();
    exp_idx = 0;
    issued = 0;
    done_cnt = 0;
    prev_stall = 0;
    prev_clken = 0;
  endtask
  task automatic go();
    model_clr();
    start = 1;
    cyc = 0;
    tick();
    start = 0;
  endtask
  task automatic wait_done(input int max);
    int w = 0;
    while (!done && w < max) begin
      tick();
      w++;
    end
    check("done_seen", 32'(done), 1);
    check("all_words", 32'(exp_idx), 64);
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_valid"}, 32'(k_valid), 0);
    check({tag, "_data"}, k_data, 0);
    check({tag, "_round"}, 32'(k_round), 0);
    check({tag, "_addr"}, 32'(ram_address), 0);
    check({tag, "_clken"}, 32'(ram_clken), 0);
  endtask
  task automatic timed_stream(input string tag, input bit hold_start);
    k_ready = 1;
    go();
    start = hold_start;
    first_v = -1;
    done_at = -1;
    check({tag, "_issue_t1"}, 32'(ram_clken), 1);
    while (cyc < 75) begin
      if (cyc >= 66) start = 0;
      if (k_valid && first_v < 0) first_v = cyc;
      if (cyc == 3) check({tag, "_k0"}, k_data, 32'h428a2f98);
      if (cyc == 66) check({tag, "_k63"}, k_data, 32'hc67178f2);
      if (cyc == 66) check({tag, "_busy66"}, 32'(busy), 1);
      if (cyc == 67) check({tag, "_busy67"}, 32'(busy), 0);
      if (done && done_at < 0) done_at = cyc;
      tick();
    end
    check({tag, "_first_valid"}, 32'(first_v), 3);
    check({tag, "_done_at"}, 32'(done_at), 67);
    check({tag, "_done_cnt"}, 32'(done_cnt), 1);
    check({tag, "_words"}, 32'(exp_idx), 64);
    check({tag, "_idle_after"}, 32'(busy), 0);
  endtask
  initial begin
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 0;
    tick();
    timed_stream("stream", 0);
    rnd_ready = 1;
    go();
    wait_done(2000);
    rnd_ready = 0;
    tick();
    k_ready = 0;
    go();
    n = 0;
    while (!k_valid && n < 10) begin
      tick();
      n++;
    end
    check("stall_first_valid", 32'(k_valid), 1);
    repeat (20) tick();
    check("stall_issued", 32'(issued), 2);
    k_ready = 1;
    wait_done(200);
    tick();
    rnd_ready = 1;
    go();
    n = 0;
    while (exp_idx < 37 && n < 2000) begin
      tick();
      n++;
    end
    rnd_ready = 0;
    k_ready = 0;
    repeat (3) tick();
    check("abort_round", 32'(k_round), 37);
    check("abort_valid_pre", 32'(k_valid), 1);
    abort = 1;
    tick();
    abort = 0;
    check("abort_valid", 32'(k_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_clken", 32'(ram_clken), 0);
    check("abort_done", 32'(done), 0);
    model_clr();
    repeat (4) tick();
    check("abort_no_done", 32'(done_cnt), 0);
    k_ready = 1;
    go();
    wait_done(200);
    tick();
    timed_stream("start_held", 1);
    model_clr();
    start = 1;
    abort = 1;
    tick();
    start = 0;
    abort = 0;
    repeat (3) tick();
    check("start_abort_busy", 32'(busy), 0);
    check("start_abort_issued", 32'(issued), 0);
    k_ready = 1;
    go();
    tick();
    check("rst_outstanding_pre", 32'(busy), 1);
    reset = 1;
    tick();
    reset = 0;
    check_idle_outputs("mid_reset");
    model_clr();
    tick();
    go();
    while (cyc < 3) tick();
    check("rst_restart_valid", 32'(k_valid), 1);
    check("rst_restart_k0", k_data, 32'h428a2f98);
    wait_done(200);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule
